im_loader: RTL and testbench

Program loader that writes instruction memory, the writer counterpart to the read-only instruction memory that the PC indexes. It accepts a byte stream over a valid/ready handshake, packs byte pairs into 16-bit instruction words (high byte first) and issues one write per word into a writable instruction RAM, starting at address 0. It holds the CPU while loading. It ends the load on the HALT word `{`HALT, 11'd0}` (`HALT` from define.v) or after address 255.

---
 rtl/im_loader.sv | 97 +++++++++
 tb/tb_im_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Program loader: packs a byte stream (high byte first) into 16-bit words and
// writes them into instruction RAM from address 0, holding the CPU meanwhile.
`ifndef HALT
`define HALT 5'b00001
`endif

module im_loader (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [7:0]  im_waddr,
  output logic [15:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic [8:0]  word_count
);

  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

  localparam logic [15:0] HALT_WORD = {`HALT, 11'd0};

  state_t      state_q, state_d;
  logic [7:0]  addr_q;
  logic [7:0]  hi_q, lo_q;
  logic [8:0]  count_q;
  logic        last_word;

  // A load ends on the HALT word (which is still written) or at the top address.
  assign last_word = ({hi_q, lo_q} == HALT_WORD) || (addr_q == 8'hFF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            addr_q  <= '0;
            count_q <= '0;
          end
        end
        HI: if (in_valid) hi_q <= in_data;
        LO: if (in_valid) lo_q <= in_data;
        WRITE: begin
          count_q <= count_q + 9'd1;
          if (!last_word) addr_q <= addr_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    im_we    = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = HI;
      HI: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) state_d = LO;
      end
      LO: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) state_d = WRITE;
      end
      WRITE: begin
        im_we    = 1'b1;
        cpu_hold = 1'b1;
        state_d  = last_word ? DONE : HI;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = HI;
      end
      default: state_d = IDLE;
    endcase
  end

  assign im_waddr   = addr_q;
  assign im_wdata   = {hi_q, lo_q};
  assign word_count = count_q;

endmodule

// File: tb/tb_im_loader.sv
// Randomised scoreboard bench for im_loader: expected RAM writes are queued
// from a word-list model and a negedge monitor pops them on every im_we.
`ifndef HALT
`define HALT 5'b00001
`endif

module tb_im_loader;

  localparam logic [15:0] HALT_W = {`HALT, 11'd0};

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, im_we, cpu_hold, done;
  logic [7:0]  im_waddr;
  logic [15:0] im_wdata;
  logic [8:0]  word_count;

  int total = 0;
  int bad = 0;
  int accepted = 0;
  logic prev_we = 1'b0;

  wr_t         exp_q[$];
  logic [15:0] words[$];

  im_loader dut (
    .clock(clock), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .word_count(word_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: checks every write against the scoreboard and counts byte transfers.
  initial begin
    forever begin
      @(negedge clock);
      if (in_valid && in_ready) accepted++;
      if (im_we) begin
        chk("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", {24'd0, im_waddr}, {24'd0, e.addr});
          chk("write_data", {16'd0, im_wdata}, {16'd0, e.data});
        end
      end
      prev_we = im_we;
    end
  end

  // Reference: words land at consecutive addresses from 0 until HALT or address 255.
  function automatic int model_load(input int limit);
    int n = 0;
    for (int k = 0; k < words.size() && k < limit; k++) begin
      wr_t w;
      w.addr = k[7:0];
      w.data = words[k];
      exp_q.push_back(w);
      n++;
      if (words[k] == HALT_W || k == 255) break;
    end
    return n;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax);
    int t = 0;
    repeat ($urandom_range(gmax, gmin)) begin
      @(posedge clock); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clock);
      t++;
    end while (!in_ready && t < 100);
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    logic pw = 1'b0;
    while (t < 2000) begin
      @(negedge clock);
      if (done) break;
      pw = im_we;
      t++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_done_after_write"}, {31'd0, pw}, 32'd1);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
  endtask

  // Runs a full load of 'words'; mid_start_word >= 0 pulses start while in LO of that word.
  task automatic run_load(input string tag, input bit do_start, input int gmin, input int gmax,
                          input int mid_start_word);
    int n, acc0;
    n = model_load(1 << 30);
    acc0 = accepted;
    if (do_start) pulse_start();
    for (int k = 0; k < n; k++) begin
      send_byte(words[k][15:8], gmin, gmax);
      if (k == mid_start_word) pulse_start();
      send_byte(words[k][7:0], gmin, gmax);
    end
    wait_done(tag);
    chk({tag, "_word_count"}, {23'd0, word_count}, n);
    chk({tag, "_bytes"}, accepted - acc0, 2 * n);
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_im_we"}, {31'd0, im_we}, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_waddr"}, {24'd0, im_waddr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, im_wdata}, 32'd0);
    chk({tag, "_word_count"}, {23'd0, word_count}, 32'd0);
  endtask

  task automatic basic_words();
    words = {16'h4c04, 16'h1100, HALT_W};
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    basic_words();
    run_load("basic", 1'b1, 0, 0, -1);

    // Reload straight from DONE using the same stream with random gaps.
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("reload_done_low", {31'd0, done}, 32'd0);
    chk("reload_hold", {31'd0, cpu_hold}, 32'd1);
    chk("reload_count", {23'd0, word_count}, 32'd0);
    chk("reload_ready", {31'd0, in_ready}, 32'd1);
    run_load("gaps", 1'b0, 1, 5, -1);

    for (int it = 0; it < 4; it++) begin
      int len;
      logic [15:0] w;
      len = $urandom_range(20, 1);
      words.delete();
      for (int k = 0; k < len; k++) begin
        do w = 16'($urandom); while (w == HALT_W);
        words.push_back(w);
      end
      words.push_back(HALT_W);
      run_load("rand", 1'b1, 0, 3, -1);
    end

    words.delete();
    for (int k = 0; k < 8; k++) words.push_back({8'(k + 8'h30), 8'(k)});
    words.push_back(HALT_W);
    run_load("mid_start", 1'b1, 0, 2, 5);

    words.delete();
    for (int unsigned k = 0; k < 256; k++) words.push_back({k[7:0], ~k[7:0]});
    words.push_back(16'h1234);
    run_load("full", 1'b1, 0, 0, -1);
    begin
      int acc0;
      acc0 = accepted;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      for (int c = 0; c < 6; c++) begin
        @(negedge clock);
        chk("full_ready_low", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("full_no_consume", accepted - acc0, 32'd0);
      chk("full_still_done", {31'd0, done}, 32'd1);
    end

    // Reset after the high byte of word 2: only words 0 and 1 may be written.
    basic_words();
    words = {16'h2222, 16'h3333, 16'h4444, HALT_W};
    void'(model_load(2));
    pulse_start();
    send_byte(words[0][15:8], 0, 1);
    send_byte(words[0][7:0], 0, 1);
    send_byte(words[1][15:8], 0, 1);
    send_byte(words[1][7:0], 0, 1);
    send_byte(words[2][15:8], 0, 1);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    repeat (3) @(negedge clock);
    chk("midreset_queue", exp_q.size(), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    basic_words();
    run_load("after_reset", 1'b1, 0, 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
